// File: rtl/pipe_ctrl_pkg.sv
// Shared control definitions for the pipe_ctrl hazard/sequencing unit:
// RV32 opcode/funct3 constants and the control-field encodings.
package pipe_ctrl_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_SLLI    = 3'b001;
    localparam logic [2:0] F3_SRXI    = 3'b101;

    typedef enum logic [2:0] {
        IMM_NONE  = 3'd0,
        IMM_I     = 3'd1,
        IMM_SHAMT = 3'd2,
        IMM_S     = 3'd3,
        IMM_B     = 3'd4,
        IMM_U     = 3'd5,
        IMM_J     = 3'd6,
        IMM_CSR   = 3'd7
    } imm_type_e;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_TARGET = 2'd1,
        PC_HOLD   = 2'd2
    } pc_sel_e;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_DMEM = 2'd1,
        WB_PC4  = 2'd2
    } wb_sel_e;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_KILL = 2'd2
    } state_e;

    typedef struct packed {
        logic       valid;
        logic       wr;
        logic [4:0] rd;
        wb_sel_e    wb_sel;
    } mw_rec_t;

    // A live MW writer to a non-zero rd that matches the X source register.
    function automatic logic fwd_hit(input mw_rec_t mw, input logic [4:0] rs);
        return mw.valid & mw.wr & (mw.rd != 5'd0) & (mw.rd == rs);
    endfunction

endpackage

// File: rtl/pipe_ctrl_x_decode.sv
// Combinational X-stage opcode classifier: immediate format, writeback
// source, redirect class and whether the instruction writes rd.
module x_decode
    import pipe_ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    output imm_type_e  o_imm_type,
    output wb_sel_e    o_wb_sel,
    output logic       o_is_jump,
    output logic       o_is_branch,
    output logic       o_is_store,
    output logic       o_is_csr,
    output logic       o_wr_rd
);

    always_comb begin
        o_imm_type  = IMM_NONE;
        o_wb_sel    = WB_ALU;
        o_is_jump   = 1'b0;
        o_is_branch = 1'b0;
        o_is_store  = 1'b0;
        o_is_csr    = 1'b0;
        case (i_opcode)
            OPC_LOAD: begin
                o_imm_type = IMM_I;
                o_wb_sel   = WB_DMEM;
            end
            OPC_OP_IMM: begin
                // Only the shift encodings carry a shamt; funct3 is ignored elsewhere.
                if (i_funct3 == F3_SLLI || i_funct3 == F3_SRXI)
                    o_imm_type = IMM_SHAMT;
                else
                    o_imm_type = IMM_I;
            end
            OPC_AUIPC, OPC_LUI: begin
                o_imm_type = IMM_U;
            end
            OPC_STORE: begin
                o_imm_type = IMM_S;
                o_is_store = 1'b1;
            end
            OPC_BRANCH: begin
                o_imm_type  = IMM_B;
                o_is_branch = 1'b1;
            end
            OPC_JALR: begin
                o_imm_type = IMM_I;
                o_wb_sel   = WB_PC4;
                o_is_jump  = 1'b1;
            end
            OPC_JAL: begin
                o_imm_type = IMM_J;
                o_wb_sel   = WB_PC4;
                o_is_jump  = 1'b1;
            end
            OPC_SYSTEM: begin
                o_imm_type = IMM_CSR;
                o_is_csr   = 1'b1;
            end
            default: begin
                o_imm_type = IMM_NONE;
            end
        endcase
    end

    assign o_wr_rd = ~(o_is_store | o_is_branch | o_is_csr);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing for a 3-stage (IF / X / MW) RV32 core: redirect
// and kill FSM, memory stall, MW writeback record and MW->X forwarding.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] x_inst,
    input  logic        x_br_taken,
    input  logic        mem_busy,
    output logic [1:0]  pc_sel,
    output logic        stall,
    output logic        x_valid,
    output logic [2:0]  imm_type,
    output logic        fwd_a,
    output logic        fwd_b,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        dmem_we,
    output logic        csr_we
);

    state_e     r_state;
    state_e     w_state_nxt;
    pc_sel_e    w_pc_sel;
    mw_rec_t    r_mw;

    imm_type_e  w_imm_type;
    wb_sel_e    w_wb_sel;
    logic       w_is_jump;
    logic       w_is_branch;
    logic       w_is_store;
    logic       w_is_csr;
    logic       w_wr_rd;
    logic       w_redirect;
    logic [4:0] w_rd;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic       w_unused_funct7;

    assign w_rd            = x_inst[11:7];
    assign w_rs1           = x_inst[19:15];
    assign w_rs2           = x_inst[24:20];
    assign w_unused_funct7 = ^x_inst[31:25];

    x_decode u_x_decode (
        .i_opcode    (x_inst[6:0]),
        .i_funct3    (x_inst[14:12]),
        .o_imm_type  (w_imm_type),
        .o_wb_sel    (w_wb_sel),
        .o_is_jump   (w_is_jump),
        .o_is_branch (w_is_branch),
        .o_is_store  (w_is_store),
        .o_is_csr    (w_is_csr),
        .o_wr_rd     (w_wr_rd)
    );

    assign w_redirect = w_is_jump | (w_is_branch & x_br_taken);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_BOOT;
        else
            r_state <= w_state_nxt;
    end

    // A stalled cycle holds the state, so a redirect blocked by mem_busy
    // fires on the first free cycle with the same X instruction.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_sel    = PC_PLUS4;
        if (mem_busy) begin
            w_pc_sel = PC_HOLD;
        end else begin
            case (r_state)
                ST_BOOT: w_state_nxt = ST_RUN;
                ST_RUN: begin
                    if (w_redirect) begin
                        w_pc_sel    = PC_TARGET;
                        w_state_nxt = ST_KILL;
                    end
                end
                ST_KILL: w_state_nxt = ST_RUN;
                default: w_state_nxt = ST_BOOT;
            endcase
        end
    end

    // MW stage boundary: record what the X instruction will retire as.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mw <= '0;
        end else if (!mem_busy) begin
            r_mw.valid  <= x_valid;
            r_mw.wr     <= w_wr_rd;
            r_mw.rd     <= w_rd;
            r_mw.wb_sel <= w_wb_sel;
        end
    end

    assign x_valid  = (r_state == ST_RUN);
    assign stall    = mem_busy;
    assign pc_sel   = rst ? PC_PLUS4 : w_pc_sel;
    assign imm_type = w_imm_type;
    assign wb_sel   = r_mw.wb_sel;

    assign rf_we    = r_mw.valid & r_mw.wr & (r_mw.rd != 5'd0) & ~mem_busy;
    assign dmem_we  = x_valid & w_is_store & ~mem_busy;
    assign csr_we   = x_valid & w_is_csr & ~mem_busy;

    assign fwd_a    = fwd_hit(r_mw, w_rs1);
    assign fwd_b    = fwd_hit(r_mw, w_rs2);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: each directed cycle pushes its
// hand-computed expected outputs; a negedge monitor pops and compares.
module tb_pipe_ctrl;

    localparam int D = -1;

    localparam logic [31:0] NOP    = 32'h00000013;
    localparam logic [31:0] ADDI5  = 32'h00100293;
    localparam logic [31:0] ADDI0  = 32'h00100013;
    localparam logic [31:0] ADD6   = 32'h00528333;
    localparam logic [31:0] BEQ    = 32'h00000463;
    localparam logic [31:0] SW     = 32'h00102023;
    localparam logic [31:0] JAL    = 32'h008000EF;
    localparam logic [31:0] JALR   = 32'h000080E7;
    localparam logic [31:0] SLLI   = 32'h00301093;
    localparam logic [31:0] LH     = 32'h00001083;
    localparam logic [31:0] LUI    = 32'h123452B7;
    localparam logic [31:0] CSRRWI = 32'h3002D073;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] x_inst = NOP;
    logic        x_br_taken = 1'b0;
    logic        mem_busy = 1'b0;
    logic [1:0]  pc_sel;
    logic        stall;
    logic        x_valid;
    logic [2:0]  imm_type;
    logic        fwd_a;
    logic        fwd_b;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic        dmem_we;
    logic        csr_we;

    pipe_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .x_inst     (x_inst),
        .x_br_taken (x_br_taken),
        .mem_busy   (mem_busy),
        .pc_sel     (pc_sel),
        .stall      (stall),
        .x_valid    (x_valid),
        .imm_type   (imm_type),
        .fwd_a      (fwd_a),
        .fwd_b      (fwd_b),
        .rf_we      (rf_we),
        .wb_sel     (wb_sel),
        .dmem_we    (dmem_we),
        .csr_we     (csr_we)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int pc, st, xv, imm, fa, fb, rf, wb, dm, cs;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   step_no = 0;

    task automatic chk(input string nm, input int idx, input int act, input int exp);
        if (exp >= 0) begin
            n_chk++;
            if (act != exp) begin
                n_fail++;
                $display("FAIL step %0d %s: got %0d expected %0d", idx, nm, act, exp);
            end
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            m_e = q.pop_front();
            chk("pc_sel",   m_e.idx, int'(pc_sel),   m_e.pc);
            chk("stall",    m_e.idx, int'(stall),    m_e.st);
            chk("x_valid",  m_e.idx, int'(x_valid),  m_e.xv);
            chk("imm_type", m_e.idx, int'(imm_type), m_e.imm);
            chk("fwd_a",    m_e.idx, int'(fwd_a),    m_e.fa);
            chk("fwd_b",    m_e.idx, int'(fwd_b),    m_e.fb);
            chk("rf_we",    m_e.idx, int'(rf_we),    m_e.rf);
            chk("wb_sel",   m_e.idx, int'(wb_sel),   m_e.wb);
            chk("dmem_we",  m_e.idx, int'(dmem_we),  m_e.dm);
            chk("csr_we",   m_e.idx, int'(csr_we),   m_e.cs);
        end
    end

    task automatic step(input logic r, input logic [31:0] inst, input logic tk, input logic bz,
                        input int pc, input int st, input int xv, input int imm, input int fa,
                        input int fb, input int rf, input int wb, input int dm, input int cs);
        exp_t e;
        @(posedge clk);
        #1;
        rst        = r;
        x_inst     = inst;
        x_br_taken = tk;
        mem_busy   = bz;
        e.idx = step_no; e.pc = pc; e.st = st; e.xv = xv; e.imm = imm;
        e.fa = fa; e.fb = fb; e.rf = rf; e.wb = wb; e.dm = dm; e.cs = cs;
        q.push_back(e);
        step_no++;
    endtask

    initial begin
        int budget;
        //    rst inst    tk bz | pc st xv imm fa fb rf wb dm cs
        step(1, NOP,    0, 0,   0, 0, 0, 1,  0, 0, 0, 0, 0, 0);  // in reset
        step(0, NOP,    0, 0,   0, 0, 0, 1,  0, 0, 0, 0, 0, 0);  // BOOT cycle
        step(0, ADDI5,  0, 0,   0, 0, 1, 1,  0, 0, 0, 0, 0, 0);
        step(0, ADD6,   0, 0,   0, 0, 1, 0,  1, 1, 1, 0, 0, 0);  // forward x5
        step(0, ADDI0,  0, 0,   0, 0, 1, 1,  0, 0, 1, 0, 0, 0);
        step(0, ADD6,   0, 0,   0, 0, 1, 0,  0, 0, 0, 0, 0, 0);  // producer rd=x0
        step(0, BEQ,    1, 0,   1, 0, 1, 4,  0, 0, 1, 0, 0, 0);  // taken
        step(0, NOP,    0, 0,   0, 0, 0, 1,  0, 0, 0, 0, 0, 0);  // killed slot
        step(0, BEQ,    0, 0,   0, 0, 1, 4,  0, 0, 0, 0, 0, 0);  // not taken
        step(0, SW,     0, 1,   2, 1, 1, 3,  0, 0, 0, 0, 0, 0);  // stall x3
        step(0, SW,     0, 1,   2, 1, 1, 3,  0, 0, 0, 0, 0, 0);
        step(0, SW,     0, 1,   2, 1, 1, 3,  0, 0, 0, 0, 0, 0);
        step(0, SW,     0, 0,   0, 0, 1, 3,  0, 0, 0, 0, 1, 0);  // store fires once
        step(0, NOP,    0, 0,   0, 0, 1, 1,  0, 0, 0, 0, 0, 0);
        step(0, ADDI5,  0, 0,   0, 0, 1, 1,  0, 0, 0, 0, 0, 0);
        step(0, NOP,    0, 1,   2, 1, 1, 1,  0, 0, 0, 0, 0, 0);  // rf_we held off
        step(0, NOP,    0, 0,   0, 0, 1, 1,  0, 0, 1, 0, 0, 0);
        step(0, JAL,    0, 1,   2, 1, 1, 6,  0, 0, 0, 0, 0, 0);  // stall beats redirect
        step(0, JAL,    0, 0,   1, 0, 1, 6,  0, 0, 0, 0, 0, 0);
        step(0, JAL,    0, 0,   0, 0, 0, 6,  0, 0, 1, 2, 0, 0);  // 2nd JAL killed
        step(0, NOP,    0, 0,   0, 0, 1, 1,  0, 0, 0, D, 0, 0);
        step(0, SLLI,   0, 0,   0, 0, 1, 2,  0, 0, 0, 0, 0, 0);
        step(0, LH,     0, 0,   0, 0, 1, 1,  0, 0, 1, 0, 0, 0);
        step(0, JALR,   0, 0,   1, 0, 1, 1,  1, 0, 1, 1, 0, 0);
        step(0, LUI,    0, 0,   0, 0, 0, 5,  0, 0, 1, 2, 0, 0);
        step(0, CSRRWI, 0, 0,   0, 0, 1, 7,  0, 0, 0, D, 0, 1);
        step(0, ADDI5,  0, 0,   0, 0, 1, 1,  0, 0, 0, 0, 0, 0);
        step(0, JAL,    0, 1,   2, 1, 1, 6,  0, 0, 0, 0, 0, 0);  // pending redirect
        step(1, JAL,    0, 1,   0, D, 0, 6,  0, 0, 0, 0, 0, 0);  // reset abandons it
        step(0, NOP,    0, 0,   0, 0, 0, 1,  0, 0, 0, 0, 0, 0);
        step(0, NOP,    0, 0,   0, 0, 1, 1,  0, 0, 0, 0, 0, 0);
        step(0, ADDI5,  0, 0,   0, 0, 1, 1,  0, 0, 0, 0, 0, 0);
        step(0, NOP,    0, 0,   0, 0, 1, 1,  0, 0, 1, 0, 0, 0);
        step(1, NOP,    0, 0,   0, 0, 0, 1,  0, 0, 0, 0, 0, 0);  // mid-run reset
        step(0, NOP,    0, 0,   0, 0, 0, 1,  0, 0, 0, 0, 0, 0);
        step(0, NOP,    0, 0,   0, 0, 1, 1,  0, 0, 0, 0, 0, 0);

        budget = 0;
        while (q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock.
REQ-002 SHALL have port rst, input, 1, reset; one clock, reset is asynchronous and active-high.
REQ-003 SHALL have port x_inst, input, 32, instruction word currently in X stage.
REQ-004 SHALL have port x_br_taken, input, 1, branch-comparator result for x_inst.
REQ-005 SHALL have port mem_busy, input, 1, memory not ready; freezes the pipeline.
REQ-006 SHALL have port pc_sel, output, 2, next PC: 0 PC+4, 1 target, 2 hold.
REQ-007 SHALL have port stall, output, 1, freeze PC and IF/X registers.
REQ-008 SHALL have port x_valid, output, 1, X instruction is architecturally live.
REQ-009 SHALL have port imm_type, output, 3, immediate format for the immediate generator.
REQ-010 SHALL have ports fwd_a and fwd_b, output, 1 each, 0 regfile, 1 MW writeback value.
REQ-011 SHALL have ports rf_we, output, 1, and wb_sel, output, 2, MW regfile write and source (0 ALU, 1 DMEM, 2 PC+4).
REQ-012 SHALL have ports dmem_we and csr_we, output, 1 each, X-stage store and CSR write strobes.

Function
REQ-013 SHALL implement FSM BOOT, RUN, KILL, with x_valid = (state==RUN).
REQ-014 SHALL move BOOT->RUN after exactly one unstalled cycle; pc_sel=0 in BOOT.
REQ-015 SHALL redirect in RUN when JAL, or JALR, or (BRANCH and x_br_taken): pc_sel=1, next state KILL.
REQ-016 SHALL move KILL->RUN after one unstalled cycle; a killed instruction never redirects or writes.
REQ-017 SHALL drive stall=mem_busy combinationally.
REQ-018 SHALL, while mem_busy=1, force pc_sel=2, hold FSM and MW record, and force rf_we=dmem_we=csr_we=0.
REQ-019 SHALL, when redirect and mem_busy coincide, let the stall win; the redirect fires in the first cycle mem_busy=0.
REQ-020 SHALL latch the MW record on each unstalled edge: mw_valid<=x_valid, mw_rd<=x_inst[11:7], mw_wr (writes rd: not STORE, BRANCH or CSR), mw_wb_sel.
REQ-021 SHALL drive rf_we = mw_valid & mw_wr & (mw_rd!=0) & !mem_busy.
REQ-022 SHALL drive fwd_a=1 iff mw_valid & mw_wr & mw_rd!=0 & mw_rd==x_inst[19:15]; fwd_b likewise with x_inst[24:20]; this holds regardless of X opcode.
REQ-023 SHALL drive dmem_we = x_valid & STORE & !mem_busy, and csr_we = x_valid & CSR & !mem_busy.
REQ-024 SHALL decode imm_type combinationally from x_inst, independent of x_valid: 0 NONE, 1 I, 2 SHAMT, 3 S, 4 B, 5 U, 6 J, 7 CSR.
REQ-025 SHALL select SHAMT only for OP-IMM with funct3 001 or 101; LOAD and JALR are always I regardless of funct3.
REQ-026 SHALL set wb_sel to 2 for JAL/JALR, 1 for LOAD, and 0 otherwise.

Reset
REQ-027 SHALL asynchronously set state=BOOT, mw_valid=0, mw_wr=0, mw_rd=0, mw_wb_sel=0 on rst.
REQ-028 SHALL hold outputs x_valid=0, rf_we=0, dmem_we=0, csr_we=0, fwd_a=fwd_b=0 and pc_sel=0 during reset, and again in the BOOT cycle after rst is released.
REQ-029 SHALL abandon any pending redirect or stall when reset is asserted mid-operation.

Structure
REQ-030 SHALL place the imm_type, pc_sel, wb_sel and FSM state encodings in a shared control-definitions header next to the opcode/funct3 constants.
REQ-031 SHALL contain one combinational sub-module x_decode (opcode -> imm_type, wb, redirect class, mw_wr); the FSM, MW record and forwarding stay in pipe_ctrl.

Verification
REQ-032 SHALL cover reset: assert rst mid-run -> x_valid=0 and rf_we=0 immediately; release -> x_valid=0 for one cycle, then 1.
REQ-033 SHALL cover branches: x_inst=0x00000463 (BEQ) with x_br_taken=1 -> pc_sel=1, x_valid=0 next cycle; with x_br_taken=0 -> pc_sel=0.
REQ-034 SHALL cover forwarding: 0x00100293 (ADDI x5) then 0x00528333 (ADD x6,x5,x5) -> fwd_a=fwd_b=1; with the producer rd=x0 -> fwd_a=fwd_b=0.
REQ-035 SHALL cover stall: 0x00102023 (SW) in X with mem_busy=1 for 3 cycles -> stall=1, pc_sel=2, dmem_we=0; dmem_we=1 for exactly one cycle after release.
REQ-036 SHALL cover imm_type: 0x00301093 (SLLI) -> 2; 0x00001083 (LH) -> 1; JALR -> 1; LUI -> 5; CSRRWI -> 7.
REQ-037 SHALL cover back-to-back JAL: exactly one pc_sel=1 pulse; the second JAL is killed with x_valid=0 and produces no rf_we.
